stack_ctrl: RTL and testbench

//  Command-side controller for the 64-entry stack memory: owns the stack pointer and turns

---
 rtl/stack_ctrl_pkg.sv | 19 +
 rtl/stack_ctrl_if.sv | 28 ++
 rtl/stack_ctrl.sv | 138 +++++++++++++
 tb/tb_stack_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared constants and types for the stack command controller.
package stack_ctrl_pkg;

  localparam int STK_REG_BITS = 32;
  localparam int STK_DEPTH    = 64;
  localparam int STK_PTR_BITS = 6;

  localparam logic [1:0] STK_OP_PUSH = 2'b00;
  localparam logic [1:0] STK_OP_POP  = 2'b01;
  localparam logic [1:0] STK_OP_POP2 = 2'b10;
  localparam logic [1:0] STK_OP_PEEK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/stack_ctrl_if.sv
// Command/response handshake bundle between datapath control and the stack controller.
interface stack_ctrl_if #(
  parameter int REG_BITS = 32
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [REG_BITS-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [REG_BITS-1:0] rsp_data0;
  logic [REG_BITS-1:0] rsp_data1;
  logic                rsp_err;

  // Command issuer / response consumer.
  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data0, rsp_data1, rsp_err
  );

  // Stack controller.
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data0, rsp_data1, rsp_err
  );

endinterface

// File: rtl/stack_ctrl.sv
// Stack controller: owns the stack pointer, issues one memory op per accepted
// command, and returns the registered read words as a held valid/ready response.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int REG_BITS = STK_REG_BITS,
  parameter int DEPTH    = STK_DEPTH,
  parameter int PTR_BITS = STK_PTR_BITS
) (
  input  logic                clk,
  input  logic                reset,
  stack_ctrl_if.slave         bus,
  output logic [PTR_BITS:0]   count,
  output logic                full,
  output logic                empty,
  output logic                StackWrite,
  output logic [REG_BITS-1:0] SP,
  output logic [REG_BITS-1:0] write_data,
  input  logic [REG_BITS-1:0] read1,
  input  logic [REG_BITS-1:0] read2
);

  state_e                state_q, state_d;
  logic [PTR_BITS:0]     count_q, count_d;
  logic [PTR_BITS-1:0]   sp_q, sp_d;
  logic [1:0]            op_q, op_d;
  logic                  err_q, err_d;
  logic [REG_BITS-1:0]   data0_q, data0_d;
  logic [REG_BITS-1:0]   data1_q, data1_d;

  logic [PTR_BITS-1:0]   sp_idx;
  logic [PTR_BITS:0]     count_m1;

  assign count_m1 = count_q - 1'b1;
  assign full     = (count_q == (PTR_BITS+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

  assign SP            = {{(REG_BITS-PTR_BITS){1'b0}}, sp_idx};
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_err   = err_q;
  assign bus.rsp_data0 = data0_q;
  assign bus.rsp_data1 = data1_q;

  // Next-state, memory command and response capture.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    count_d       = count_q;
    sp_d          = sp_q;
    op_d          = op_q;
    err_d         = err_q;
    data0_d       = data0_q;
    data1_d       = data1_q;
    sp_idx        = sp_q;
    StackWrite    = 1'b0;
    write_data    = '0;
    bus.cmd_ready = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        sp_idx        = empty ? '0 : count_m1[PTR_BITS-1:0];
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          err_d   = 1'b0;
          data0_d = '0;
          data1_d = '0;
          state_d = ST_MEM;
          unique case (bus.cmd_op)
            STK_OP_PUSH: begin
              if (full) begin
                err_d = 1'b1;
              end else begin
                sp_idx     = count_q[PTR_BITS-1:0];
                StackWrite = 1'b1;
                write_data = bus.cmd_data;
                count_d    = count_q + 1'b1;
              end
            end
            STK_OP_POP: begin
              if (empty) err_d = 1'b1;
              else       count_d = count_m1;
            end
            STK_OP_POP2: begin
              // Gating on count>=2 keeps the memory's SP-1 read in range.
              if (count_q < (PTR_BITS+1)'(2)) err_d = 1'b1;
              else                            count_d = count_q - (PTR_BITS+1)'(2);
            end
            default: begin  // PEEK
              if (empty) err_d = 1'b1;
            end
          endcase
          sp_d = sp_idx;
        end
      end
      ST_MEM: begin
        state_d = ST_RESP;
        if (!err_q && op_q != STK_OP_PUSH) data0_d = read1;
        if (!err_q && op_q == STK_OP_POP2) data1_d = read2;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The memory must never be written or see a stale SP while reset is held.
    if (reset) begin
      StackWrite = 1'b0;
      sp_idx     = '0;
    end
  end

  // State and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      sp_q    <= '0;
      op_q    <= STK_OP_PUSH;
      err_q   <= 1'b0;
      // NOTE: response data registers are reset because they are visible outputs; the stack memory itself is not.
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sp_q    <= sp_d;
      op_q    <= op_d;
      err_q   <= err_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural 64-entry stack memory.
module tb_stack_ctrl;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_POP2 = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  count;
  logic        full, empty, StackWrite;
  logic [31:0] SP, write_data, read1, read2;

  int checks   = 0;
  int failures = 0;

  stack_ctrl_if #(.REG_BITS(32)) bus ();

  stack_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .StackWrite (StackWrite),
    .SP         (SP),
    .write_data (write_data),
    .read1      (read1),
    .read2      (read2)
  );

  always #5 clk = ~clk;

  // Stack memory: write-first, registered reads of stack[SP] and stack[SP-1].
  logic [31:0] mem [0:63];
  logic [5:0]  mem_idx;
  logic [5:0]  mem_idx_m1;
  assign mem_idx    = SP[5:0];
  assign mem_idx_m1 = mem_idx - 6'd1;

  always @(posedge clk) begin
    if (StackWrite) mem[mem_idx] <= write_data;
    read1 <= StackWrite ? write_data : mem[mem_idx];
    read2 <= mem[mem_idx_m1];
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic        exp_err;
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;
    logic [6:0]  exp_count;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Offer one command, capture accept-cycle StackWrite/SP, wait for rsp_valid.
  task automatic do_cmd(input logic [1:0] op, input logic [31:0] data,
                        output logic sw, output logic [31:0] sp, output int lat);
    @(negedge clk);
    check("cmd_ready_at_accept", {31'b0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    #1;
    sw = StackWrite;
    sp = SP;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run_vec(input string name, input logic [1:0] op, input logic [31:0] data,
                         input logic exp_err, input logic [31:0] exp_d0, input logic [31:0] exp_d1,
                         input logic [6:0] exp_count, output logic sw, output logic [31:0] sp);
    int lat;
    do_cmd(op, data, sw, sp, lat);
    check({name, "_latency"}, lat, 32'd2);
    check({name, "_err"}, {31'b0, bus.rsp_err}, {31'b0, exp_err});
    check({name, "_d0"}, bus.rsp_data0, exp_d0);
    check({name, "_d1"}, bus.rsp_data1, exp_d1);
    check({name, "_count"}, {25'b0, count}, {25'b0, exp_count});
    finish_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        sw;
    logic [31:0] sp;
    int          lat;

    vecs[0] = '{OP_POP,  32'h0,  1'b1, 32'h0, 32'h0, 7'd0};
    vecs[1] = '{OP_PUSH, 32'hA,  1'b0, 32'h0, 32'h0, 7'd1};
    vecs[2] = '{OP_PUSH, 32'hB,  1'b0, 32'h0, 32'h0, 7'd2};
    vecs[3] = '{OP_POP2, 32'h0,  1'b0, 32'hB, 32'hA, 7'd0};
    vecs[4] = '{OP_PUSH, 32'h7,  1'b0, 32'h0, 32'h0, 7'd1};
    vecs[5] = '{OP_POP2, 32'h0,  1'b1, 32'h0, 32'h0, 7'd1};
    vecs[6] = '{OP_PEEK, 32'h0,  1'b0, 32'h7, 32'h0, 7'd1};
    vecs[7] = '{OP_POP,  32'h0,  1'b0, 32'h7, 32'h0, 7'd0};
    vecs[8] = '{OP_PEEK, 32'h0,  1'b1, 32'h0, 32'h0, 7'd0};

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_PUSH;
    bus.cmd_data  = 32'h0;
    bus.rsp_ready = 1'b0;

    // Reset held with a PUSH offered: memory must not be written.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 32'hDEAD;
    #1;
    check("stackwrite_in_reset", {31'b0, StackWrite}, 32'd0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("reset_count", {25'b0, count}, 32'd0);
    check("reset_empty", {31'b0, empty}, 32'd1);
    check("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("reset_sp", SP, 32'd0);
    reset = 1'b0;

    // Table of single commands.
    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].exp_err,
              vecs[i].exp_d0, vecs[i].exp_d1, vecs[i].exp_count, sw, sp);
    end
    check("empty_after_table", {31'b0, empty}, 32'd1);

    // Fill to full; each legal PUSH writes at SP=count.
    for (int i = 0; i < 64; i++) begin
      run_vec($sformatf("fill%0d", i), OP_PUSH, i, 1'b0, 32'h0, 32'h0, 7'(i + 1), sw, sp);
      check($sformatf("fill%0d_sw", i), {31'b0, sw}, 32'd1);
      check($sformatf("fill%0d_sp", i), sp, i);
    end
    check("full_flag", {31'b0, full}, 32'd1);
    run_vec("push_full", OP_PUSH, 32'hFF, 1'b1, 32'h0, 32'h0, 7'd64, sw, sp);
    check("push_full_sw", {31'b0, sw}, 32'd0);
    run_vec("peek_full", OP_PEEK, 32'h0, 1'b0, 32'h3F, 32'h0, 7'd64, sw, sp);
    run_vec("pop2_full", OP_POP2, 32'h0, 1'b0, 32'h3F, 32'h3E, 7'd62, sw, sp);
    check("not_full", {31'b0, full}, 32'd0);

    // Response stall: data held and no new command accepted.
    do_reset();
    run_vec("push5", OP_PUSH, 32'h5, 1'b0, 32'h0, 32'h0, 7'd1, sw, sp);
    do_cmd(OP_PEEK, 32'h0, sw, sp, lat);
    check("stall_latency", lat, 32'd2);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_valid", i), {31'b0, bus.rsp_valid}, 32'd1);
      check($sformatf("stall%0d_d0", i), bus.rsp_data0, 32'h5);
      check($sformatf("stall%0d_ready", i), {31'b0, bus.cmd_ready}, 32'd0);
      @(negedge clk);
    end
    finish_rsp();
    check("stall_idle_ready", {31'b0, bus.cmd_ready}, 32'd1);

    // Reset while a POP is in MEM: response dropped.
    run_vec("push9a", OP_PUSH, 32'h9, 1'b0, 32'h0, 32'h0, 7'd2, sw, sp);
    run_vec("push9b", OP_PUSH, 32'h9, 1'b0, 32'h0, 32'h0, 7'd3, sw, sp);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_POP;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    reset         = 1'b1;
    check("mem_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drop%0d_rsp_valid", i), {31'b0, bus.rsp_valid}, 32'd0);
      @(negedge clk);
    end
    check("drop_count", {25'b0, count}, 32'd0);
    check("drop_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
